// File: rtl/cordic_nco_sequencer.sv
// cordic_nco_sequencer: phase accumulator that feeds a cosine stage one angle at a
// time through a start/done/ready handshake. Results are buffered in a small FIFO
// for a valid/ready consumer.
// Optional build macro CORDIC_NCO_STALL_CNT_EN adds a 16-bit saturating stall_cycles
// output. It counts cycles spent idle with enable high and the FIFO full.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no conversion in flight; issue when enabled, ready, FIFO slot free
// BUSY      | request held stable on cordic_angle/cordic_start until done
// WAIT_CLR  | result stored; waiting for cordic_done to drop before next issue
module cordic_nco_sequencer #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] phase_inc,
  input  logic             phase_load,
  input  logic [WIDTH-1:0] phase_init,
  output logic [WIDTH-1:0] cordic_angle,
  output logic             cordic_start,
  input  logic             cordic_ready,
  input  logic             cordic_done,
  input  logic [WIDTH-1:0] cordic_value,
  output logic [WIDTH-1:0] sample_data,
  output logic             sample_valid,
  input  logic             sample_ready
`ifdef CORDIC_NCO_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_WAIT_CLR} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_phase;
  logic [WIDTH-1:0] r_angle;
  logic             r_start;
  logic             r_skip_inc;

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_push = (r_state == ST_BUSY) && cordic_done;
  assign w_pop  = (r_count != '0) && sample_ready;

  assign cordic_angle = r_angle;
  assign cordic_start = r_start;
  assign sample_valid = (r_count != '0);
  assign sample_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

  // Handshake FSM with registered request outputs and the phase accumulator.
  // A load during BUSY makes the loaded value the next issued angle. The increment
  // tied to the in-flight conversion is therefore skipped (r_skip_inc).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_phase    <= '0;
      r_angle    <= '0;
      r_start    <= 1'b0;
      r_skip_inc <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable && cordic_ready && !w_full) begin
            r_angle <= r_phase;
            r_start <= 1'b1;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cordic_done) begin
            r_start <= 1'b0;
            r_state <= ST_WAIT_CLR;
          end
        end
        ST_WAIT_CLR: begin
          if (!cordic_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (phase_load) begin
        r_phase    <= phase_init;
        r_skip_inc <= (r_state == ST_BUSY) && !cordic_done;
      end else if (w_push) begin
        if (!r_skip_inc) r_phase <= r_phase + phase_inc;
        r_skip_inc <= 1'b0;
      end
    end
  end

  // Sample FIFO: push on conversion completion, pop on consumer handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= cordic_value;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef CORDIC_NCO_STALL_CNT_EN
  logic [15:0] r_stall;
  assign stall_cycles = r_stall;

  // Saturating count of cycles where issue is blocked only by a full FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall <= '0;
    end else if (enable && (r_state == ST_IDLE) && w_full && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cordic_nco_sequencer.sv
// Directed bench for cordic_nco_sequencer with a behavioural cosine-stage model.
// The model returns ~angle after a random latency of 5-40 cycles.
module tb_cordic_nco_sequencer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] phase_inc;
  logic        phase_load;
  logic [31:0] phase_init;
  logic [31:0] cordic_angle;
  logic        cordic_start;
  logic        cordic_ready;
  logic        cordic_done;
  logic [31:0] cordic_value;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
`ifdef CORDIC_NCO_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;

  cordic_nco_sequencer #(.WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .phase_inc    (phase_inc),
    .phase_load   (phase_load),
    .phase_init   (phase_init),
    .cordic_angle (cordic_angle),
    .cordic_start (cordic_start),
    .cordic_ready (cordic_ready),
    .cordic_done  (cordic_done),
    .cordic_value (cordic_value),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready)
`ifdef CORDIC_NCO_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cosine-stage model: accept a request, wait, raise done, and hold done until start drops.
  int          m_st;
  int          m_cnt;
  logic [31:0] m_angle;
  initial begin
    m_st = 0; m_cnt = 0; m_angle = '0;
    cordic_ready = 1'b1; cordic_done = 1'b0; cordic_value = '0;
    forever begin
      @(posedge clk);
      #1;
      case (m_st)
        0: if (cordic_start) begin
             m_angle = cordic_angle;
             m_cnt = int'($urandom_range(40, 5));
             cordic_ready = 1'b0;
             m_st = 1;
           end
        1: begin
             m_cnt = m_cnt - 1;
             if (m_cnt == 0) begin
               cordic_done  = 1'b1;
               cordic_value = ~m_angle;
               m_st = 2;
             end
           end
        2: if (!cordic_start) begin
             cordic_done = 1'b0;
             m_st = 3;
           end
        default: begin
             cordic_ready = 1'b1;
             m_st = 0;
           end
      endcase
    end
  end

  // Observer: record issued angles, popped samples, and any angle change while start is held.
  logic [31:0] angle_q[$];
  logic [31:0] samp_q[$];
  logic        prev_start = 1'b0;
  logic [31:0] prev_angle = '0;
  int          unstable = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (cordic_start && !prev_start) angle_q.push_back(cordic_angle);
      if (cordic_start && prev_start && (cordic_angle !== prev_angle)) unstable <= unstable + 1;
      if (sample_valid && sample_ready) samp_q.push_back(sample_data);
    end
    prev_start <= cordic_start;
    prev_angle <= cordic_angle;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_angles(input int n, input int budget);
    for (int i = 0; i < budget && angle_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic wait_samples(input int n, input int budget);
    for (int i = 0; i < budget && samp_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic drain(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  logic [31:0] a0;
  logic [15:0] s1;
  logic        found;

  initial begin
    reset = 1'b0; enable = 1'b0; phase_inc = '0; phase_load = 1'b0;
    phase_init = '0; sample_ready = 1'b0;

    // Reset values, checked before any clock edge.
    #2;
    chk("rst_start", {31'd0, cordic_start}, 32'd0);
    chk("rst_angle", cordic_angle, 32'd0);
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_data", sample_data, 32'd0);
`ifdef CORDIC_NCO_STALL_CNT_EN
    chk("rst_stall", {16'd0, stall_cycles}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Quarter-turn sweep that wraps back to zero.
    phase_inc = 32'h4000_0000; sample_ready = 1'b1; enable = 1'b1;
    wait_angles(5, 400);
    @(posedge clk); #1 enable = 1'b0;
    wait_samples(5, 200);
    drain(60);
    chk("sweep_n_angles", angle_q.size(), 32'd5);
    chk("sweep_n_samples", samp_q.size(), 32'd5);
    if (angle_q.size() >= 5 && samp_q.size() >= 5) begin
      chk("sweep_a0", angle_q[0], 32'h0000_0000);
      chk("sweep_a1", angle_q[1], 32'h4000_0000);
      chk("sweep_a2", angle_q[2], 32'h8000_0000);
      chk("sweep_a3", angle_q[3], 32'hC000_0000);
      chk("sweep_a4", angle_q[4], 32'h0000_0000);
      chk("sweep_s0", samp_q[0], 32'hFFFF_FFFF);
      chk("sweep_s1", samp_q[1], 32'hBFFF_FFFF);
      chk("sweep_s2", samp_q[2], 32'h7FFF_FFFF);
      chk("sweep_s3", samp_q[3], 32'h3FFF_FFFF);
      chk("sweep_s4", samp_q[4], 32'hFFFF_FFFF);
    end

    // Full FIFO: four conversions, then issue stalls until the consumer drains.
    angle_q.delete(); samp_q.delete();
    @(posedge clk); #1;
    sample_ready = 1'b0; enable = 1'b1;
    drain(300);
    chk("full_n_angles", angle_q.size(), 32'd4);
    chk("full_valid", {31'd0, sample_valid}, 32'd1);
    chk("full_start", {31'd0, cordic_start}, 32'd0);
    if (angle_q.size() >= 4) begin
      chk("full_a0", angle_q[0], 32'h4000_0000);
      chk("full_a3", angle_q[3], 32'h0000_0000);
    end
`ifdef CORDIC_NCO_STALL_CNT_EN
    s1 = stall_cycles;
    chk("stall_nonzero", {31'd0, (s1 != 16'd0)}, 32'd1);
    drain(10);
    chk("stall_inc10", {16'd0, stall_cycles}, {16'd0, s1 + 16'd10});
`endif
    @(posedge clk); #1 sample_ready = 1'b1;
    wait_samples(6, 600);
    enable = 1'b0;
    drain(80);
    chk("full_no_loss", samp_q.size(), angle_q.size());
    for (int i = 0; i < samp_q.size() && i < angle_q.size(); i++)
      chk($sformatf("full_order%0d", i), samp_q[i], ~angle_q[i]);
    if (samp_q.size() >= 4) begin
      chk("full_s0", samp_q[0], 32'hBFFF_FFFF);
      chk("full_s3", samp_q[3], 32'hFFFF_FFFF);
    end

    // Phase load while a conversion is in flight.
    angle_q.delete(); samp_q.delete();
    @(posedge clk); #1;
    phase_inc = 32'h0100_0000; enable = 1'b1; unstable = 0;
    wait_angles(1, 100);
    a0 = (angle_q.size() > 0) ? angle_q[0] : 32'hxxxx_xxxx;
    @(posedge clk); #1 phase_load = 1'b1; phase_init = 32'hAAAA_AAAA;
    @(posedge clk); #1 phase_load = 1'b0;
    chk("load_inflight_angle", cordic_angle, a0);
    wait_angles(3, 300);
    enable = 1'b0;
    drain(80);
    chk("load_stable", unstable, 32'd0);
    chk("load_n_angles", angle_q.size(), 32'd3);
    if (angle_q.size() >= 3) begin
      chk("load_next", angle_q[1], 32'hAAAA_AAAA);
      chk("load_after", angle_q[2], 32'hABAA_AAAA);
    end
    chk("load_n_samples", samp_q.size(), 32'd3);

    // Enable dropped one cycle after the request rises.
    angle_q.delete(); samp_q.delete();
    @(posedge clk); #1 enable = 1'b1;
    wait_angles(1, 100);
    @(posedge clk); #1 enable = 1'b0;
    drain(120);
    chk("drop_n_angles", angle_q.size(), 32'd1);
    chk("drop_n_samples", samp_q.size(), 32'd1);
    chk("drop_start", {31'd0, cordic_start}, 32'd0);
    if (angle_q.size() >= 1 && samp_q.size() >= 1)
      chk("drop_sample", samp_q[0], ~angle_q[0]);

    // Asynchronous reset with a buffered sample and a second conversion in flight.
    angle_q.delete(); samp_q.delete();
    @(posedge clk); #1 sample_ready = 1'b0; enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (sample_valid && cordic_start) found = 1'b1;
    end
    chk("arst_setup", {31'd0, found}, 32'd1);
    @(posedge clk); #3 reset = 1'b0;
    #1;
    chk("arst_start", {31'd0, cordic_start}, 32'd0);
    chk("arst_valid", {31'd0, sample_valid}, 32'd0);
    chk("arst_data", sample_data, 32'd0);
    chk("arst_angle", cordic_angle, 32'd0);
    enable = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #2;
      if (cordic_done) found = 1'b1;
    end
    chk("arst_done_seen", {31'd0, found}, 32'd1);
    reset = 1'b1; sample_ready = 1'b1;
    drain(20);
    chk("arst_no_push", samp_q.size(), 32'd0);
    chk("arst_valid_after", {31'd0, sample_valid}, 32'd0);
    angle_q.delete();
    @(posedge clk); #1 phase_inc = 32'h1234_5678; enable = 1'b1;
    wait_angles(2, 300);
    enable = 1'b0;
    drain(80);
    chk("arst_n_angles", angle_q.size(), 32'd2);
    if (angle_q.size() >= 2) begin
      chk("arst_phase0", angle_q[0], 32'h0000_0000);
      chk("arst_phase1", angle_q[1], 32'h1234_5678);
    end

    // Simultaneous push and pop with one sample buffered.
    angle_q.delete(); samp_q.delete();
    @(posedge clk); #1 sample_ready = 1'b0; enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #2;
      if (cordic_done && sample_valid) found = 1'b1;
    end
    chk("b2b_setup", {31'd0, found}, 32'd1);
    sample_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    chk("b2b_valid", {31'd0, sample_valid}, 32'd1);
    if (angle_q.size() >= 2) chk("b2b_data", sample_data, ~angle_q[1]);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_empty", {31'd0, sample_valid}, 32'd0);
    drain(80);
    chk("b2b_n_samples", samp_q.size(), 32'd2);
    if (samp_q.size() >= 2 && angle_q.size() >= 2) begin
      chk("b2b_s0", samp_q[0], ~angle_q[0]);
      chk("b2b_s1", samp_q[1], ~angle_q[1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_nco_sequencer.md
CORDIC_NCO_SEQUENCER -- requirements
Module: cordic_nco_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: angle and sample width; 2^WIDTH angle units = 2*pi.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output sample buffer entries; power of 2, >= 2.
REQ-003 SHALL have ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  run; new conversions issued only while high.
- phase_inc  input  WIDTH  unsigned phase increment per sample.
- phase_load  input  1  load phase accumulator from phase_init.
- phase_init  input  WIDTH  load value.
- cordic_angle  output  WIDTH  angle to the cosine stage.
- cordic_start  output  1  conversion request to the cosine stage.
- cordic_ready  input  1  cosine stage idle.
- cordic_done  input  1  cosine result valid.
- cordic_value  input  WIDTH  signed cosine result.
- sample_data  output  WIDTH  signed FIFO head sample.
- sample_valid  output  1  FIFO non-empty.
- sample_ready  input  1  consumer accepts sample_data.

Function
REQ-004 SHALL hold a WIDTH-bit phase accumulator; addition is modulo 2^WIDTH (silent wrap, no saturation).
REQ-005 SHALL implement FSM states IDLE, BUSY, WAIT_CLR.
REQ-006 IDLE -> BUSY when enable && cordic_ready && (fifo_count < FIFO_DEPTH); on that edge: cordic_angle <= phase, cordic_start <= 1.
REQ-007 In BUSY, cordic_start and cordic_angle SHALL stay stable until cordic_done == 1.
REQ-008 BUSY with cordic_done == 1: push cordic_value into FIFO, cordic_start <= 0, phase <= phase + phase_inc; go to WAIT_CLR.
REQ-009 WAIT_CLR -> IDLE when cordic_done == 0; no new request may issue before cordic_done is low.
REQ-010 Issue-to-start latency SHALL be one cycle: qualifying IDLE condition at edge N gives cordic_start high after edge N.
REQ-011 At most one conversion SHALL be in flight; REQ-006 slot check guarantees no push to a full FIFO.
REQ-012 phase_load SHALL set phase <= phase_init on the next edge in any state; it overrides a same-cycle increment (REQ-008), which is discarded.
REQ-013 phase_load in BUSY SHALL NOT alter cordic_angle of the in-flight conversion.
REQ-014 enable deasserted in BUSY/WAIT_CLR: the in-flight conversion SHALL complete and its sample SHALL be stored; no further issue.
REQ-015 FIFO: sample_valid = (count != 0); sample_data = oldest entry; pop on sample_valid && sample_ready.
REQ-016 Simultaneous push and pop: count unchanged, order preserved; pop with empty FIFO is ignored.
REQ-017 Samples SHALL emerge in issue order, bit-exact to cordic_value.

Reset
REQ-018 reset low SHALL immediately, without a clock, force: state IDLE, phase 0, cordic_angle 0, cordic_start 0, FIFO empty, sample_valid 0, sample_data 0, and the stall counter (REQ-020) to 0.
REQ-019 Reset asserted mid-conversion SHALL discard the conversion. After release, cordic_done still high from the previous conversion SHALL NOT push a sample: the FSM starts in IDLE.

Configuration
REQ-020 With CORDIC_NCO_STALL_CNT_EN defined: add output stall_cycles (16 bits), incremented each cycle that enable == 1, state == IDLE and the FIFO is full; saturates at 16'hFFFF.
REQ-021 Without CORDIC_NCO_STALL_CNT_EN: no stall_cycles port and no counter logic; all other behaviour identical.

Verification
Bench uses a behavioural cosine-stage model with the same start/done/ready handshake and variable 5-40 cycle latency.
REQ-022 Sweep with wrap: reset, phase_inc = 0x40000000, enable = 1, sample_ready = 1 -> cordic_angle sequence 0x00000000, 0x40000000, 0x80000000, 0xC0000000, 0x00000000; samples match the model in order.
REQ-023 Full FIFO: sample_ready = 0, FIFO_DEPTH = 4 -> exactly 4 conversions, then cordic_start stays 0 and stall_cycles increments (macro on). Raise sample_ready -> issuing resumes; no sample lost or duplicated.
REQ-024 Load during BUSY: phase_load with phase_init = 0xAAAAAAAA while BUSY -> in-flight cordic_angle unchanged; next issued angle = 0xAAAAAAAA; following angle = 0xAAAAAAAA + phase_inc.
REQ-025 Enable drop: enable -> 0 one cycle after cordic_start rises -> exactly one sample delivered; cordic_start stays 0 thereafter.
REQ-026 Async reset: reset low mid-BUSY between clock edges -> cordic_start = 0 and sample_valid = 0 before the next edge. Release with model done still high -> no sample pushed.
REQ-027 Back-to-back pop/push: sample_ready = 1 held while a sample lands with count = 1 -> count stays 1, data order correct.
